// File: rtl/vdatabus_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : vdatabus_responder_if
//  Purpose  : Versat databus bundle for N_PORTS masters, ports packed with
//             port 0 at the MSB end of every vector.
//  Revision : 1.0  initial release
// ============================================================================
interface vdatabus_responder_if #(
   parameter int N_PORTS = 2,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32
);
   logic [N_PORTS-1:0]          valid;
   logic [N_PORTS-1:0]          ready;
   logic [N_PORTS*ADDR_W-1:0]   addr;
   logic [N_PORTS*DATA_W-1:0]   wdata;
   logic [N_PORTS*DATA_W/8-1:0] wstrb;
   logic [N_PORTS*DATA_W-1:0]   rdata;

   modport master (output valid, addr, wdata, wstrb, input ready, rdata);
   modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface
`default_nettype wire

// File: rtl/vdatabus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : vdatabus_responder
//  Purpose  : Responder end of the Versat databus. Round-robin arbitration of
//             N_PORTS masters onto one byte-writable single-port RAM; one
//             access per IDLE -> ACCESS -> RESP pass.
//  Revision : 1.0  initial release
// ============================================================================
module vdatabus_responder #(
   parameter int N_PORTS    = 2,
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int MEM_ADDR_W = 10
) (
   input  wire logic               clk,
   input  wire logic               rst,
   vdatabus_responder_if.slave     s_databus,
   output logic                    busy
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int DEPTH  = 1 << MEM_ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // per-port views of the packed bus, index i = port i
   logic [N_PORTS-1:0] port_valid;
   logic [ADDR_W-1:0]  port_addr  [N_PORTS];
   logic [DATA_W-1:0]  port_wdata [N_PORTS];
   logic [STRB_W-1:0]  port_wstrb [N_PORTS];

   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_found;
   int                 cand;

   logic [IDX_W-1:0]   gnt_idx;
   logic [ADDR_W-1:0]  gnt_addr;
   logic [DATA_W-1:0]  gnt_wdata;
   logic [STRB_W-1:0]  gnt_wstrb;
   logic [DATA_W-1:0]  rd_word;

   logic [MEM_ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0]     mem [DEPTH];

   generate
      for (genvar i = 0; i < N_PORTS; i++) begin : g_port
         assign port_valid[i] = s_databus.valid[N_PORTS-1-i];
         assign port_addr[i]  = s_databus.addr[(N_PORTS-i)*ADDR_W-1 -: ADDR_W];
         assign port_wdata[i] = s_databus.wdata[(N_PORTS-i)*DATA_W-1 -: DATA_W];
         assign port_wstrb[i] = s_databus.wstrb[(N_PORTS-i)*STRB_W-1 -: STRB_W];
         // response is only driven toward the granted port while in RESP
         assign s_databus.ready[N_PORTS-1-i] =
            (state == ST_RESP) && (gnt_idx == IDX_W'(i));
         assign s_databus.rdata[(N_PORTS-i)*DATA_W-1 -: DATA_W] =
            ((state == ST_RESP) && (gnt_idx == IDX_W'(i))) ? rd_word : '0;
      end
   endgenerate

   // Upper address bits alias onto the RAM; they are captured but never decoded.
   assign ram_addr = gnt_addr[MEM_ADDR_W-1:0];
   generate
      if (ADDR_W > MEM_ADDR_W) begin : g_alias
         logic addr_hi_unused;
         assign addr_hi_unused = ^gnt_addr[ADDR_W-1:MEM_ADDR_W];
      end
   endgenerate

   assign busy = (state != ST_IDLE);

   // Round-robin search starting at rr_ptr; first requesting port wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int k = 0; k < N_PORTS; k++) begin
         cand = (int'(rr_ptr) + k) % N_PORTS;
         if (!pick_found && port_valid[IDX_W'(cand)]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(cand);
         end
      end
   end

   // Next-state logic: only IDLE waits on a condition.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (pick_found) state_nxt = ST_ACCESS;
         ST_ACCESS: state_nxt = ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Capture the winning request and advance the round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr    <= '0;
         gnt_idx   <= '0;
         gnt_addr  <= '0;
         gnt_wdata <= '0;
         gnt_wstrb <= '0;
      end else if (state == ST_IDLE && pick_found) begin
         gnt_idx   <= pick_idx;
         gnt_addr  <= port_addr[pick_idx];
         gnt_wdata <= port_wdata[pick_idx];
         gnt_wstrb <= port_wstrb[pick_idx];
         rr_ptr    <= (pick_idx == IDX_W'(N_PORTS-1)) ? '0 : pick_idx + IDX_W'(1);
      end
   end

   // Single-port RAM, read-before-write; a reset in ACCESS cancels the write.
   always_ff @(posedge clk) begin
      if (!rst && state == ST_ACCESS) begin
         rd_word <= mem[ram_addr];
         for (int b = 0; b < STRB_W; b++) begin
            if (gnt_wstrb[b]) mem[ram_addr][b*8 +: 8] <= gnt_wdata[b*8 +: 8];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vdatabus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vdatabus_responder
//  Purpose  : Self-checking bench for vdatabus_responder with a scoreboard of
//             expected responses built from a reference memory model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vdatabus_responder;

   localparam int N_PORTS    = 2;
   localparam int ADDR_W     = 12;
   localparam int DATA_W     = 32;
   localparam int MEM_ADDR_W = 10;
   localparam int STRB_W     = DATA_W / 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   bit   mon_en = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vdatabus_responder_if #(.N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   vdatabus_responder #(
      .N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(MEM_ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .s_databus(bus), .busy(busy)
   );

   typedef struct {
      int                        cyc;
      logic [N_PORTS-1:0]        ready;
      logic [N_PORTS*DATA_W-1:0] rdata;
   } obs_t;

   typedef struct {
      int                port;
      int                issue;
      logic [DATA_W-1:0] data;
      bit                chk;
   } exp_t;

   obs_t              obs_q[$];
   exp_t              exp_q[$];
   logic [DATA_W-1:0] mdl [int];

   // record every response pulse, sampled mid-cycle
   always @(negedge clk) begin
      obs_t t;
      if (mon_en && bus.ready !== '0) begin
         t.cyc = cyc; t.ready = bus.ready; t.rdata = bus.rdata;
         obs_q.push_back(t);
      end
   end

   function automatic logic [N_PORTS-1:0] exp_ready(input int p);
      logic [N_PORTS-1:0] v;
      v = '0; v[N_PORTS-1-p] = 1'b1;
      return v;
   endfunction

   function automatic logic [N_PORTS*DATA_W-1:0] exp_rdata(input int p, input logic [DATA_W-1:0] d);
      logic [N_PORTS*DATA_W-1:0] v;
      v = '0; v[(N_PORTS-p)*DATA_W-1 -: DATA_W] = d;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_req(input int p, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
      bus.valid[N_PORTS-1-p] = 1'b1;
      bus.addr[(N_PORTS-p)*ADDR_W-1 -: ADDR_W]  = a;
      bus.wdata[(N_PORTS-p)*DATA_W-1 -: DATA_W] = d;
      bus.wstrb[(N_PORTS-p)*STRB_W-1 -: STRB_W] = s;
   endtask

   task automatic clr_req(input int p);
      bus.valid[N_PORTS-1-p] = 1'b0;
   endtask

   // model: expected response is the old word (if known); then apply the write
   task automatic push_exp(input int p, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s, input int issue);
      exp_t              e;
      int                m;
      logic [DATA_W-1:0] w;
      m = int'(a) % (1 << MEM_ADDR_W);
      e.port = p; e.issue = issue; e.chk = mdl.exists(m);
      e.data = e.chk ? mdl[m] : '0;
      if (s != '0) begin
         w = e.data;
         for (int b = 0; b < STRB_W; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
         mdl[m] = w;
      end
      exp_q.push_back(e);
   endtask

   task automatic wait_obs(input int n);
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         if (obs_q.size() >= n) break;
      end
   endtask

   task automatic run_one(input int p, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
      tick();
      set_req(p, a, d, s);
      push_exp(p, a, d, s, cyc);
      wait_obs(exp_q.size());
      #1;
      clr_req(p);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      n_cmp++; if (bus.ready !== '0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.ready); end
      n_cmp++; if (bus.rdata !== '0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      tick();
      rst = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_write_read();
      exp_t e; obs_t o;
      run_one(0, 12'd5, 32'hDEADBEEF, 4'hF);
      run_one(0, 12'd5, 32'h0, 4'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL wr_missing: port %0d no ready, want ready", e.port); end
         else begin
            o = obs_q.pop_front();
            if (o.ready !== exp_ready(e.port)) begin n_fail++; $display("FAIL wr_ready: got %b want %b", o.ready, exp_ready(e.port)); end
            n_cmp++; if (o.cyc - e.issue != 2) begin n_fail++; $display("FAIL wr_latency: got %0d want 2", o.cyc - e.issue); end
            if (e.chk) begin
               n_cmp++; if (o.rdata !== exp_rdata(e.port, e.data)) begin n_fail++; $display("FAIL wr_rdata: got %h want %h", o.rdata, exp_rdata(e.port, e.data)); end
            end
         end
      end
      n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL wr_extra: got %0d stray readies want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_byte_strobe();
      exp_t e; obs_t o;
      run_one(0, 12'd7, 32'h11223344, 4'hF);
      run_one(0, 12'd7, 32'h0000AA00, 4'h2);
      run_one(0, 12'd7, 32'h0, 4'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL bs_missing: port %0d no ready, want ready", e.port); end
         else begin
            o = obs_q.pop_front();
            if (o.ready !== exp_ready(e.port)) begin n_fail++; $display("FAIL bs_ready: got %b want %b", o.ready, exp_ready(e.port)); end
            if (e.chk) begin
               n_cmp++; if (o.rdata !== exp_rdata(e.port, e.data)) begin n_fail++; $display("FAIL bs_rdata: got %h want %h", o.rdata, exp_rdata(e.port, e.data)); end
            end
         end
      end
      n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL bs_extra: got %0d stray readies want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_alias();
      exp_t e; obs_t o;
      run_one(0, 12'h405, 32'h0, 4'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL al_missing: port %0d no ready, want ready", e.port); end
         else begin
            o = obs_q.pop_front();
            if (o.rdata !== exp_rdata(e.port, e.data)) begin n_fail++; $display("FAIL al_rdata: got %h want %h", o.rdata, exp_rdata(e.port, e.data)); end
         end
      end
      n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL al_extra: got %0d stray readies want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_drop_valid();
      exp_t e; obs_t o;
      tick();
      set_req(1, 12'd5, 32'h0, 4'h0);
      push_exp(1, 12'd5, 32'h0, 4'h0, cyc);
      tick();
      clr_req(1);
      wait_obs(exp_q.size());
      repeat (8) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL dv_missing: port %0d no ready, want ready", e.port); end
         else begin
            o = obs_q.pop_front();
            if (o.ready !== exp_ready(e.port)) begin n_fail++; $display("FAIL dv_ready: got %b want %b", o.ready, exp_ready(e.port)); end
            n_cmp++; if (o.cyc - e.issue != 2) begin n_fail++; $display("FAIL dv_latency: got %0d want 2", o.cyc - e.issue); end
            n_cmp++; if (o.rdata !== exp_rdata(e.port, e.data)) begin n_fail++; $display("FAIL dv_rdata: got %h want %h", o.rdata, exp_rdata(e.port, e.data)); end
         end
      end
      n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL dv_extra: got %0d stray readies want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_reset_abort();
      exp_t e; obs_t o;
      run_one(0, 12'd3, 32'h0, 4'hF);
      tick();
      set_req(0, 12'd3, 32'h00000055, 4'hF);
      tick();
      rst = 1'b1;
      clr_req(0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ra_busy: got %b want 0", busy); end
      n_cmp++; if (bus.ready !== '0) begin n_fail++; $display("FAIL ra_ready: got %b want 0", bus.ready); end
      repeat (4) tick();
      run_one(0, 12'd3, 32'h0, 4'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL ra_missing: port %0d no ready, want ready", e.port); end
         else begin
            o = obs_q.pop_front();
            if (o.ready !== exp_ready(e.port)) begin n_fail++; $display("FAIL ra_ready_seq: got %b want %b", o.ready, exp_ready(e.port)); end
            if (e.chk) begin
               n_cmp++; if (o.rdata !== exp_rdata(e.port, e.data)) begin n_fail++; $display("FAIL ra_rdata: got %h want %h", o.rdata, exp_rdata(e.port, e.data)); end
            end
         end
      end
      n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL ra_extra: got %0d stray readies want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_round_robin();
      exp_t e; obs_t o; int t0;
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      tick();
      set_req(0, 12'd5, 32'h0, 4'h0);
      set_req(1, 12'd7, 32'h0, 4'h0);
      t0 = cyc;
      push_exp(0, 12'd5, 32'h0, 4'h0, t0);
      push_exp(1, 12'd7, 32'h0, 4'h0, t0 + 3);
      push_exp(0, 12'd5, 32'h0, 4'h0, t0 + 6);
      push_exp(1, 12'd7, 32'h0, 4'h0, t0 + 9);
      wait_obs(4);
      #1;
      clr_req(0);
      clr_req(1);
      repeat (6) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL rr_missing: port %0d no ready, want ready", e.port); end
         else begin
            o = obs_q.pop_front();
            if (o.ready !== exp_ready(e.port)) begin n_fail++; $display("FAIL rr_order: got %b want %b", o.ready, exp_ready(e.port)); end
            n_cmp++; if (o.cyc - e.issue != 2) begin n_fail++; $display("FAIL rr_spacing: got %0d want 2 from slot start", o.cyc - e.issue); end
            n_cmp++; if (o.rdata !== exp_rdata(e.port, e.data)) begin n_fail++; $display("FAIL rr_rdata: got %h want %h", o.rdata, exp_rdata(e.port, e.data)); end
         end
      end
      n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rr_extra: got %0d stray readies want 0", obs_q.size()); obs_q.delete(); end
   endtask

   initial begin
      bus.valid = '0;
      bus.addr  = '0;
      bus.wdata = '0;
      bus.wstrb = '0;
      test_reset();
      test_write_read();
      test_byte_strobe();
      test_alias();
      test_drop_valid();
      test_reset_abort();
      test_round_robin();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
